// File: rtl/adc_chan_demux_if.sv
// Frame input and per-channel demux results of adc_chan_demux.
interface adc_chan_demux_if #(
  parameter int unsigned DATA_W  = 13,
  parameter int unsigned CH_BITS = 2,
  parameter int unsigned NUM_CH  = 4
);
  logic [DATA_W+CH_BITS-1:0] frame;
  logic                      frame_valid;
  logic [NUM_CH-1:0]         clear_fresh;
  logic                      avg_restart;
  logic [NUM_CH*DATA_W-1:0]  ch_data;
  logic [NUM_CH*DATA_W-1:0]  ch_avg;
  logic [NUM_CH-1:0]         ch_fresh;
  logic [NUM_CH-1:0]         avg_valid;
  logic                      all_fresh;
  logic [NUM_CH-1:0]         stale;
  logic                      addr_err;

  modport master (
    output frame, frame_valid, clear_fresh, avg_restart,
    input  ch_data, ch_avg, ch_fresh, avg_valid, all_fresh, stale, addr_err
  );
  modport slave (
    input  frame, frame_valid, clear_fresh, avg_restart,
    output ch_data, ch_avg, ch_fresh, avg_valid, all_fresh, stale, addr_err
  );
endinterface

// File: rtl/adc_chan_demux.sv
// Demultiplexes addressed ADC frames into per-channel latest sample, block
// average, freshness and staleness state.
module adc_chan_demux #(
  parameter int unsigned DATA_W   = 13,
  parameter int unsigned CH_BITS  = 2,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned AVG_LOG2 = 2,
  parameter bit          SIGNED   = 1'b0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic             clk,
  input logic             rst,
  adc_chan_demux_if.slave bus
);
  localparam int unsigned ACC_W    = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ST_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned WIN_LAST = (1 << AVG_LOG2) - 1;

  logic [DATA_W-1:0]  sample;
  logic [CH_BITS-1:0] addr;
  logic [ACC_W-1:0]   sample_ext;

  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] data_d [NUM_CH];
  logic [DATA_W-1:0] avg_q  [NUM_CH];
  logic [DATA_W-1:0] avg_d  [NUM_CH];
  logic [ACC_W-1:0]  acc_q  [NUM_CH];
  logic [ACC_W-1:0]  acc_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [ST_W-1:0]   st_q   [NUM_CH];
  logic [ST_W-1:0]   st_d   [NUM_CH];
  logic [NUM_CH-1:0] fresh_q, fresh_d;
  logic [NUM_CH-1:0] avg_vld_q, avg_vld_d;
  logic [NUM_CH-1:0] stale_q, stale_d;
  logic              all_fresh_q, all_fresh_d;
  logic              addr_err_q, addr_err_d;

  assign sample = bus.frame[DATA_W-1:0];
  assign addr   = bus.frame[DATA_W +: CH_BITS];

  // Sample widened to accumulator width, sign-extended for two's complement data.
  always_comb begin
    if (SIGNED) sample_ext = ACC_W'($signed(sample));
    else        sample_ext = ACC_W'(sample);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        data_q[k] <= '0;
        avg_q[k]  <= '0;
        acc_q[k]  <= '0;
        cnt_q[k]  <= '0;
        st_q[k]   <= '0;
      end
      fresh_q     <= '0;
      avg_vld_q   <= '0;
      stale_q     <= '0;
      all_fresh_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      data_q      <= data_d;
      avg_q       <= avg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      fresh_q     <= fresh_d;
      avg_vld_q   <= avg_vld_d;
      stale_q     <= stale_d;
      all_fresh_q <= all_fresh_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Next-state logic for every channel
  always_comb begin : next_state
    logic             hit;
    logic [ACC_W-1:0] base_acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] base_cnt;

    data_d     = data_q;
    avg_d      = avg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    fresh_d    = fresh_q;
    stale_d    = stale_q;
    avg_vld_d  = '0;
    hit        = 1'b0;
    base_acc   = '0;
    sum        = '0;
    base_cnt   = '0;
    addr_err_d = bus.frame_valid && (32'(addr) >= NUM_CH);

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      hit      = bus.frame_valid && (32'(addr) == k);
      // A restart drops the partial window before any coincident sample lands.
      base_acc = bus.avg_restart ? '0 : acc_q[k];
      base_cnt = bus.avg_restart ? '0 : cnt_q[k];
      sum      = base_acc + sample_ext;
      acc_d[k] = base_acc;
      cnt_d[k] = base_cnt;

      if (hit) begin
        data_d[k] = sample;
        if (32'(base_cnt) == WIN_LAST) begin
          if (SIGNED) avg_d[k] = DATA_W'($signed(sum) >>> AVG_LOG2);
          else        avg_d[k] = DATA_W'(sum >> AVG_LOG2);
          avg_vld_d[k] = 1'b1;
          acc_d[k]     = '0;
          cnt_d[k]     = '0;
        end else begin
          acc_d[k] = sum;
          cnt_d[k] = base_cnt + CNT_W'(1);
        end
      end

      if (hit)                      fresh_d[k] = 1'b1;
      else if (bus.clear_fresh[k])  fresh_d[k] = 1'b0;

      if (hit)                            st_d[k] = '0;
      else if (st_q[k] != ST_W'(TIMEOUT)) st_d[k] = st_q[k] + ST_W'(1);
      stale_d[k] = (st_d[k] == ST_W'(TIMEOUT));
    end

    all_fresh_d = &fresh_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign bus.ch_data[k*DATA_W +: DATA_W] = data_q[k];
    assign bus.ch_avg[k*DATA_W +: DATA_W]  = avg_q[k];
  end

  assign bus.ch_fresh  = fresh_q;
  assign bus.avg_valid = avg_vld_q;
  assign bus.stale     = stale_q;
  assign bus.all_fresh = all_fresh_q;
  assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_adc_chan_demux.sv
// Drives an unsigned 4-channel and a signed 3-channel demux in lockstep and
// checks both against a per-channel arithmetic model.
module tb_adc_chan_demux;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] frame;
  logic        fv;
  logic [3:0]  clr;
  logic        restart;

  adc_chan_demux_if #(.DATA_W(13), .CH_BITS(2), .NUM_CH(4)) ifa ();
  adc_chan_demux_if #(.DATA_W(13), .CH_BITS(2), .NUM_CH(3)) ifb ();

  assign ifa.frame       = frame;
  assign ifa.frame_valid = fv;
  assign ifa.clear_fresh = clr;
  assign ifa.avg_restart = restart;
  assign ifb.frame       = frame;
  assign ifb.frame_valid = fv;
  assign ifb.clear_fresh = clr[2:0];
  assign ifb.avg_restart = restart;

  adc_chan_demux #(.DATA_W(13), .CH_BITS(2), .NUM_CH(4), .AVG_LOG2(2),
                   .SIGNED(1'b0), .TIMEOUT(TMO))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));

  adc_chan_demux #(.DATA_W(13), .CH_BITS(2), .NUM_CH(3), .AVG_LOG2(2),
                   .SIGNED(1'b1), .TIMEOUT(TMO))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int avv_a0;

  // Reference state: index 0 = unsigned 4-channel, 1 = signed 3-channel
  int m_data [2][4];
  int m_avg  [2][4];
  int m_ctr  [2][4];
  int w_sum  [2][4];
  int w_n    [2][4];
  bit m_fresh[2][4];
  bit m_avv  [2][4];
  bit m_err  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int floor_div(input int s, input int n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_data[d][k] = 0; m_avg[d][k] = 0; m_ctr[d][k] = 0;
        w_sum[d][k] = 0;  w_n[d][k] = 0;
        m_fresh[d][k] = 1'b0; m_avv[d][k] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    int  a, s, v;
    bit  hit;
    a = int'(frame[14:13]);
    s = int'(frame[12:0]);
    for (int d = 0; d < 2; d++) begin
      m_err[d] = fv && (a >= nch(d));
      for (int k = 0; k < nch(d); k++) begin
        hit = fv && (a == k);
        m_avv[d][k] = 1'b0;
        if (restart) begin w_sum[d][k] = 0; w_n[d][k] = 0; end
        if (hit) begin
          m_data[d][k] = s;
          v = (d == 1 && s >= 4096) ? s - 8192 : s;
          w_sum[d][k] += v;
          w_n[d][k]++;
          if (w_n[d][k] == 4) begin
            m_avg[d][k] = floor_div(w_sum[d][k], 4) & 32'h1FFF;
            m_avv[d][k] = 1'b1;
            w_sum[d][k] = 0;
            w_n[d][k]   = 0;
          end
        end
        if (hit)         m_fresh[d][k] = 1'b1;
        else if (clr[k]) m_fresh[d][k] = 1'b0;
        m_ctr[d][k] = hit ? 0 : ((m_ctr[d][k] < TMO) ? m_ctr[d][k] + 1 : TMO);
      end
    end
  endtask

  task automatic compare_dut(input int d, input logic [63:0] o_data, input logic [63:0] o_avg,
                             input logic [3:0] o_fresh, input logic [3:0] o_avv,
                             input logic o_af, input logic [3:0] o_stale, input logic o_err);
    logic [63:0] ed, ea;
    logic [3:0]  ef, ev, es;
    logic        af;
    ed = '0; ea = '0; ef = '0; ev = '0; es = '0; af = 1'b1;
    for (int k = 0; k < nch(d); k++) begin
      ed[k*13 +: 13] = 13'(m_data[d][k]);
      ea[k*13 +: 13] = 13'(m_avg[d][k]);
      ef[k] = m_fresh[d][k];
      ev[k] = m_avv[d][k];
      es[k] = (m_ctr[d][k] == TMO);
      af    = af & m_fresh[d][k];
    end
    check($sformatf("d%0d_ch_data", d),   o_data, ed);
    check($sformatf("d%0d_ch_avg", d),    o_avg, ea);
    check($sformatf("d%0d_ch_fresh", d),  64'(o_fresh), 64'(ef));
    check($sformatf("d%0d_avg_valid", d), 64'(o_avv), 64'(ev));
    check($sformatf("d%0d_all_fresh", d), 64'(o_af), 64'(af));
    check($sformatf("d%0d_stale", d),     64'(o_stale), 64'(es));
    check($sformatf("d%0d_addr_err", d),  64'(o_err), 64'(m_err[d]));
  endtask

  // Advance one clock: model the edge, then compare everything 1 time unit later.
  task automatic step();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
    compare_dut(0, 64'(ifa.ch_data), 64'(ifa.ch_avg), ifa.ch_fresh, ifa.avg_valid,
                ifa.all_fresh, ifa.stale, ifa.addr_err);
    compare_dut(1, 64'(ifb.ch_data), 64'(ifb.ch_avg), 4'(ifb.ch_fresh), 4'(ifb.avg_valid),
                ifb.all_fresh, 4'(ifb.stale), ifb.addr_err);
    if (ifa.avg_valid[0]) avv_a0++;
  endtask

  task automatic idle_inputs();
    fv = 1'b0; frame = '0; clr = '0; restart = 1'b0;
  endtask

  task automatic send(input int ch, input int s, input logic [3:0] c);
    fv = 1'b1; frame = {2'(ch), 13'(s)}; clr = c; restart = 1'b0;
    step();
    idle_inputs();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    logic [63:0] exp_vec;
    rst = 1'b1;
    idle_inputs();
    avv_a0 = 0;
    repeat (3) step();
    rst = 1'b0;

    // One frame per channel on consecutive cycles; address 3 is out of range for the 3-channel DUT.
    send(0, 13'h0123, 4'h0);
    send(1, 13'h0456, 4'h0);
    send(2, 13'h0789, 4'h0);
    send(3, 13'h1FFF, 4'h0);
    exp_vec = {12'h0, 13'h1FFF, 13'h0789, 13'h0456, 13'h0123};
    check("scn_data", 64'(ifa.ch_data), exp_vec);
    check("scn_all_fresh", 64'(ifa.all_fresh), 64'd1);
    check("scn_addr_err", 64'(ifb.addr_err), 64'd1);
    step();
    check("scn_addr_err_gone", 64'(ifb.addr_err), 64'd0);

    // Four-sample unsigned average, truncated.
    pulse_restart();
    avv_a0 = 0;
    for (int i = 0; i < 4; i++) send(0, 10 + i, 4'h0);
    check("avg_10_13", 64'(ifa.ch_avg[12:0]), 64'd11);
    step();
    check("avg_pulse_once", 64'(avv_a0), 64'd1);

    // Negative samples on the signed DUT: -10 >>> 2 = -3.
    pulse_restart();
    for (int i = 0; i < 4; i++) send(1, 8191 - i, 4'h0);
    check("signed_avg", 64'(ifb.ch_avg[25:13]), 64'h1FFD);

    // Clear coincident with a frame loses; clear alone wins.
    send(2, 13'h0AAA, 4'b0100);
    check("clr_vs_set", 64'(ifa.ch_fresh[2]), 64'd1);
    clr = 4'b0100;
    step();
    idle_inputs();
    check("clr_alone", 64'(ifa.ch_fresh[2]), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      fv      = 1'($urandom_range(0, 1));
      frame   = 15'($urandom);
      clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      restart = ($urandom_range(0, 31) == 0);
      step();
    end
    idle_inputs();

    // Silence long enough for every channel to go stale.
    repeat (TMO + 6) step();
    check("stale_all_a", 64'(ifa.stale), 64'hF);
    check("stale_all_b", 64'(ifb.stale), 64'h7);
    send(0, 13'h0055, 4'h0);
    check("stale_ch0_a", 64'(ifa.stale), 64'hE);
    check("stale_ch0_b", 64'(ifb.stale), 64'h6);

    // Reset mid-window discards the partial sum.
    pulse_restart();
    send(0, 100, 4'h0);
    send(0, 100, 4'h0);
    #2;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    avv_a0 = 0;
    for (int i = 0; i < 4; i++) send(0, 8, 4'h0);
    step();
    check("post_rst_avg_a", 64'(ifa.ch_avg[12:0]), 64'd8);
    check("post_rst_avg_b", 64'(ifb.ch_avg[12:0]), 64'd8);
    check("post_rst_pulses", 64'(avv_a0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_chan_demux.md
ADC_CHAN_DEMUX -- requirements
Module: adc_chan_demux

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 13, meaning sample width in bits.
REQ-002 The block SHALL expose parameter CH_BITS, default 2, meaning width of the channel-address field.
REQ-003 The block SHALL expose parameter NUM_CH, default 4, meaning implemented channel count; legal range 1..2^CH_BITS.
REQ-004 The block SHALL expose parameter AVG_LOG2, default 2, meaning each average spans 2^AVG_LOG2 samples; 0 disables averaging, so the average equals the sample.
REQ-005 The block SHALL expose parameter SIGNED, default 0, meaning 1 treats samples as two's complement.
REQ-006 The block SHALL expose parameter TIMEOUT, default 1024, meaning clocks without a sample before a channel is flagged stale.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is clocked on the rising edge of clk.
REQ-008 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 Port frame, input, DATA_W+CH_BITS bits: {channel address, sample}, with the sample at [DATA_W-1:0].
REQ-010 Port frame_valid, input, 1 bit: single-cycle strobe qualifying frame.
REQ-011 Port clear_fresh, input, NUM_CH bits: per-channel acknowledge that clears the fresh flag.
REQ-012 Port avg_restart, input, 1 bit: discards all partial averaging windows.
REQ-013 Port ch_data, output, NUM_CH*DATA_W bits: latest sample per channel; channel k occupies [k*DATA_W +: DATA_W].
REQ-014 Port ch_avg, output, NUM_CH*DATA_W bits: latest completed average per channel, packed the same way as ch_data.
REQ-015 Port ch_fresh, output, NUM_CH bits: a new sample has arrived since the last clear.
REQ-016 Port avg_valid, output, NUM_CH bits: one-cycle pulse when that channel's ch_avg updates.
REQ-017 Port all_fresh, output, 1 bit: AND of ch_fresh.
REQ-018 Port stale, output, NUM_CH bits: no sample on that channel for TIMEOUT clocks.
REQ-019 Port addr_err, output, 1 bit: one-cycle pulse for a frame whose address is >= NUM_CH.

Function
REQ-020 A frame_valid at edge N with address k < NUM_CH SHALL update ch_data[k] and set ch_fresh[k], both visible after edge N; latency 1 clock.
REQ-021 Frames with address >= NUM_CH SHALL leave all channel state unchanged and pulse addr_err for exactly one cycle after the edge.
REQ-022 When frame_valid is low, all channel state SHALL hold; no update occurs without frame_valid.
REQ-023 clear_fresh[k] SHALL clear ch_fresh[k] at the next edge; when it coincides with a frame for channel k, the set SHALL win and ch_fresh[k] = 1.
REQ-024 Each channel SHALL keep an accumulator of DATA_W+AVG_LOG2 bits, sign-extended when SIGNED = 1, and a sample count of AVG_LOG2 bits.
REQ-025 On the frame that completes a window (count = 2^AVG_LOG2-1), the block SHALL load ch_avg[k] = (acc + sample) >> AVG_LOG2, pulse avg_valid[k] in the same cycle ch_avg[k] changes, and reset acc and count to 0.
REQ-026 The right shift in REQ-025 SHALL be arithmetic when SIGNED = 1 and logical otherwise; it truncates and never rounds.
REQ-027 avg_restart SHALL zero every accumulator and count; a coincident frame SHALL become sample 1 of the new window (acc = sample, count = 1), and ch_avg SHALL keep its value.
REQ-028 Each channel SHALL run a stale counter that increments every clock and saturates at TIMEOUT.
REQ-029 A valid frame for a channel SHALL reset that channel's stale counter to 0 and deassert its stale bit at the same edge.
REQ-030 stale[k] SHALL be 1 exactly when the channel's counter equals TIMEOUT.
REQ-031 Frames for different channels on consecutive cycles SHALL all be accepted; back-to-back frames to the same channel SHALL each update state, with no dropped frames.
REQ-032 all_fresh SHALL be a registered or combinational AND of ch_fresh, and SHALL reflect ch_fresh within the same cycle.

Reset
REQ-033 While rst is high, ch_data, ch_avg, all accumulators and counts, and all stale counters SHALL be 0.
REQ-034 While rst is high, ch_fresh, avg_valid, all_fresh, stale and addr_err SHALL be 0.
REQ-035 Assertion of rst mid-window SHALL discard the partial average; the first post-reset frame SHALL be sample 1 of a new window.

Verification
REQ-036 Scenario with defaults: frames 0x0123 (ch0), 0x2456 (ch1), 0x4789 (ch2), 0x7FFF (ch3), one per cycle -> ch_data = 0x0123, 0x0456, 0x0789, 0x1FFF; all_fresh = 1 one cycle after the last frame.
REQ-037 Scenario: four ch0 samples 10, 11, 12, 13 -> avg_valid[0] pulses once, with ch_avg[0] = 11 (46>>2, truncated).
REQ-038 Scenario with SIGNED = 1: ch1 samples -1, -2, -3, -4 -> ch_avg[1] = -3 (-10 arithmetic-shifted right by 2).
REQ-039 Scenario: clear_fresh[2] coincident with a ch2 frame -> ch_fresh[2] = 1; clear alone on the next cycle -> 0.
REQ-040 Scenario with NUM_CH = 3: a frame addressed to channel 3 -> addr_err pulses for 1 cycle and ch_data is unchanged; with no frames for 1024 clocks -> stale = 3'b111, and a ch0 frame clears stale[0] only.
REQ-041 Scenario: rst asserted after 2 of 4 window samples, then 4 new ch0 samples of 8 -> ch_avg[0] = 8, with exactly one avg_valid pulse.
